// File: rtl/prbs_pkg.sv
// prbs_pkg: shared PRBS definitions for the per-lane generator and monitor.
//   - polynomial select encodings and tap pairs (b[n] = b[n-A] ^ b[n-B])
//   - prbs_next(): next DATA_WIDTH-bit word that follows a given word
//   - popcount(): number of set bits, used for bit-error counting
// Words are LSB-oldest: bit 0 of a word is the earliest bit in the stream.
package prbs_pkg;

  // Widest word any instance may use; functions work on this width and
  // callers zero-extend / truncate to their own DATA_WIDTH.
  localparam int unsigned MAX_W = 128;
  // Enough bits to hold popcount of a MAX_W word (0..128).
  localparam int unsigned POP_W = 8;

  typedef enum logic [1:0] {
    POLY_PRBS7  = 2'd0,
    POLY_PRBS15 = 2'd1,
    POLY_PRBS23 = 2'd2,
    POLY_PRBS31 = 2'd3
  } poly_e;

  localparam int unsigned TAP_A_PRBS7  = 6;
  localparam int unsigned TAP_B_PRBS7  = 7;
  localparam int unsigned TAP_A_PRBS15 = 14;
  localparam int unsigned TAP_B_PRBS15 = 15;
  localparam int unsigned TAP_A_PRBS23 = 18;
  localparam int unsigned TAP_B_PRBS23 = 23;
  localparam int unsigned TAP_A_PRBS31 = 28;
  localparam int unsigned TAP_B_PRBS31 = 31;

  typedef enum logic {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } mon_state_e;

  // Extend the stream 'width' bits past 'word'. Output bit i is stream bit
  // width+i; its taps either fall inside the new word (already computed,
  // lower index) or reach back into the previous word. Because width >= 31
  // and every tap <= 31, the previous word always covers the reach-back.
  function automatic logic [MAX_W-1:0] prbs_extend(
    input logic [MAX_W-1:0] word,
    input int unsigned      tap_a,
    input int unsigned      tap_b,
    input int unsigned      width
  );
    logic [MAX_W-1:0] nxt;
    logic [6:0]       ia;
    logic [6:0]       ib;
    logic             ba;
    logic             bb;
    nxt = '0;
    for (int unsigned i = 0; i < MAX_W; i++) begin
      if (i < width) begin
        ia = (i >= tap_a) ? 7'(i - tap_a) : 7'(width + i - tap_a);
        ib = (i >= tap_b) ? 7'(i - tap_b) : 7'(width + i - tap_b);
        ba = (i >= tap_a) ? nxt[ia] : word[ia];
        bb = (i >= tap_b) ? nxt[ib] : word[ib];
        nxt[i] = ba ^ bb;
      end
    end
    return nxt;
  endfunction

  // Next word of the selected sequence; 'width' is the caller's DATA_WIDTH.
  function automatic logic [MAX_W-1:0] prbs_next(
    input logic [MAX_W-1:0] word,
    input logic [1:0]       sel,
    input int unsigned      width
  );
    logic [MAX_W-1:0] res;
    case (sel)
      POLY_PRBS7:  res = prbs_extend(word, TAP_A_PRBS7,  TAP_B_PRBS7,  width);
      POLY_PRBS15: res = prbs_extend(word, TAP_A_PRBS15, TAP_B_PRBS15, width);
      POLY_PRBS23: res = prbs_extend(word, TAP_A_PRBS23, TAP_B_PRBS23, width);
      default:     res = prbs_extend(word, TAP_A_PRBS31, TAP_B_PRBS31, width);
    endcase
    return res;
  endfunction

  function automatic logic [POP_W-1:0] popcount(input logic [MAX_W-1:0] v);
    logic [POP_W-1:0] cnt;
    cnt = '0;
    for (int unsigned i = 0; i < MAX_W; i++) begin
      cnt = cnt + POP_W'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/prbs_mon.sv
// prbs_mon: per-lane self-synchronising PRBS checker with BER counters.
// Ports:
//   rx_user_clk_i  clock (only clock)
//   rx_user_rst_i  synchronous active-high reset
//   poly_sel_i     0=PRBS7 1=PRBS15 2=PRBS23 3=PRBS31
//   clear_i        zero both counters (wins over a same-cycle increment)
//   rx_data_i      received word, bit 0 oldest
//   rx_valid_i     word qualifier; when low everything holds
//   locked_o       checker locked
//   err_o          one-cycle pulse for a mismatching word while locked
//   err_cnt_o      saturating bit-error count (locked words only)
//   word_cnt_o     saturating count of words checked while locked
// DATA_WIDTH must lie in 31..128 so one word always spans the longest tap.
module prbs_mon
  import prbs_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ERR_CNT_WIDTH = 32,
  parameter int unsigned LOCK_GOOD_CNT = 16,
  parameter int unsigned LOCK_BAD_CNT  = 4
) (
  input  logic                     rx_user_clk_i,
  input  logic                     rx_user_rst_i,
  input  logic [1:0]               poly_sel_i,
  input  logic                     clear_i,
  input  logic [DATA_WIDTH-1:0]    rx_data_i,
  input  logic                     rx_valid_i,
  output logic                     locked_o,
  output logic                     err_o,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt_o,
  output logic [ERR_CNT_WIDTH-1:0] word_cnt_o
);

  localparam int unsigned GOOD_W = $clog2(LOCK_GOOD_CNT + 1);
  localparam int unsigned BAD_W  = $clog2(LOCK_BAD_CNT + 1);
  localparam int unsigned SUM_W  = ERR_CNT_WIDTH + POP_W;
  localparam logic [SUM_W-1:0] CNT_MAX_EXT = SUM_W'({ERR_CNT_WIDTH{1'b1}});

  mon_state_e               state_q, state_d;
  logic                     seeded_q, seeded_d;
  logic [DATA_WIDTH-1:0]    exp_q, exp_d;       // expected next word
  logic [GOOD_W-1:0]        good_q, good_d;
  logic [BAD_W-1:0]         bad_q, bad_d;
  logic                     err_q, err_d;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
  logic [ERR_CNT_WIDTH-1:0] word_cnt_q, word_cnt_d;
  logic [1:0]               poly_q;

  logic [DATA_WIDTH-1:0]    pred_rx;
  logic [DATA_WIDTH-1:0]    pred_ref;
  logic [DATA_WIDTH-1:0]    diff;
  logic                     mismatch;
  logic [POP_W-1:0]         nerr;
  logic [SUM_W-1:0]         err_sum;
  logic [ERR_CNT_WIDTH-1:0] err_inc;

  assign pred_rx  = DATA_WIDTH'(prbs_next(MAX_W'(rx_data_i), poly_q, DATA_WIDTH));
  assign pred_ref = DATA_WIDTH'(prbs_next(MAX_W'(exp_q), poly_q, DATA_WIDTH));
  assign diff     = rx_data_i ^ exp_q;
  assign mismatch = |diff;
  assign nerr     = popcount(MAX_W'(diff));
  assign err_sum  = SUM_W'(err_cnt_q) + SUM_W'(nerr);
  assign err_inc  = (err_sum > CNT_MAX_EXT) ? '1 : err_sum[ERR_CNT_WIDTH-1:0];

  always_comb begin
    state_d    = state_q;
    seeded_d   = seeded_q;
    exp_d      = exp_q;
    good_d     = good_q;
    bad_d      = bad_q;
    err_d      = 1'b0;
    err_cnt_d  = err_cnt_q;
    word_cnt_d = word_cnt_q;

    if (poly_sel_i != poly_q) begin
      // Polynomial change: restart acquisition, keep the counters.
      state_d  = ST_SEARCH;
      seeded_d = 1'b0;
      good_d   = '0;
      bad_d    = '0;
    end else if (rx_valid_i) begin
      case (state_q)
        ST_SEARCH: begin
          // Self-sync: always predict from what was actually received.
          exp_d = pred_rx;
          if (!seeded_q) begin
            seeded_d = 1'b1;
          end else if (!mismatch) begin
            if (good_q == GOOD_W'(LOCK_GOOD_CNT - 1)) begin
              state_d = ST_LOCKED;
              good_d  = '0;
              bad_d   = '0;
            end else begin
              good_d = good_q + 1'b1;
            end
          end else begin
            good_d = '0;
          end
        end
        ST_LOCKED: begin
          // Free-running reference: received errors never feed back. This
          // also holds on the word that drops lock, so a clean stream after
          // a burst matches immediately and relocks after LOCK_GOOD_CNT words.
          exp_d     = pred_ref;
          err_d     = mismatch;
          err_cnt_d = err_inc;
          if (word_cnt_q != '1) begin
            word_cnt_d = word_cnt_q + 1'b1;
          end
          if (mismatch) begin
            if (bad_q == BAD_W'(LOCK_BAD_CNT - 1)) begin
              state_d = ST_SEARCH;
              good_d  = '0;
              bad_d   = '0;
            end else begin
              bad_d = bad_q + 1'b1;
            end
          end else begin
            bad_d = '0;
          end
        end
      endcase
    end

    if (clear_i) begin
      err_cnt_d  = '0;
      word_cnt_d = '0;
    end
  end

  always_ff @(posedge rx_user_clk_i) begin
    if (rx_user_rst_i) begin
      state_q    <= ST_SEARCH;
      seeded_q   <= 1'b0;
      exp_q      <= '0;
      good_q     <= '0;
      bad_q      <= '0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      seeded_q   <= seeded_d;
      exp_q      <= exp_d;
      good_q     <= good_d;
      bad_q      <= bad_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
      word_cnt_q <= word_cnt_d;
    end
    // Tracked through reset too, so leaving reset is not seen as a change.
    poly_q <= poly_sel_i;
  end

  assign locked_o   = (state_q == ST_LOCKED);
  assign err_o      = err_q;
  assign err_cnt_o  = err_cnt_q;
  assign word_cnt_o = word_cnt_q;

endmodule

// File: tb/tb_prbs_mon.sv
// tb_prbs_mon: directed/randomised bench for prbs_mon. A serial bit-level
// PRBS generator produces reference words; expected counts come from the
// sequence of injected errors.
module tb_prbs_mon;

  localparam int DW = 64;
  localparam int SW = 40;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    sel;
  logic          clear, valid;
  logic [DW-1:0] data;
  logic          locked, err;
  logic [31:0]   err_cnt, word_cnt;

  logic          clear_s, valid_s;
  logic [SW-1:0] data_s;
  logic          locked_s, err_s;
  logic [3:0]    err_cnt_s, word_cnt_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  prbs_mon #(.DATA_WIDTH(DW), .ERR_CNT_WIDTH(32)) dut (
    .rx_user_clk_i(clk), .rx_user_rst_i(rst), .poly_sel_i(sel),
    .clear_i(clear), .rx_data_i(data), .rx_valid_i(valid),
    .locked_o(locked), .err_o(err), .err_cnt_o(err_cnt), .word_cnt_o(word_cnt)
  );

  prbs_mon #(.DATA_WIDTH(SW), .ERR_CNT_WIDTH(4)) dut_sat (
    .rx_user_clk_i(clk), .rx_user_rst_i(rst), .poly_sel_i(sel),
    .clear_i(clear_s), .rx_data_i(data_s), .rx_valid_i(valid_s),
    .locked_o(locked_s), .err_o(err_s), .err_cnt_o(err_cnt_s), .word_cnt_o(word_cnt_s)
  );

  // Serial reference generator: b[n] = b[n-A] ^ b[n-B].
  bit gq[$];
  int ga, gb;

  task automatic gen_init(input int s);
    case (s)
      0:       begin ga = 6;  gb = 7;  end
      1:       begin ga = 14; gb = 15; end
      2:       begin ga = 18; gb = 23; end
      default: begin ga = 28; gb = 31; end
    endcase
    gq.delete();
    for (int i = 0; i < gb; i++) gq.push_back(bit'($urandom_range(0, 1)));
    gq[0] = 1'b1;
  endtask

  task automatic gen_word(input int w, output logic [127:0] v);
    bit nb;
    v = '0;
    for (int i = 0; i < w; i++) begin
      nb = gq[gq.size() - ga] ^ gq[gq.size() - gb];
      gq.push_back(nb);
      v[i] = nb;
      if (gq.size() > 64) void'(gq.pop_front());
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive at the falling edge; on return the outputs reflect this word.
  task automatic send(input logic [127:0] w);
    data  = w[DW-1:0];
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic send_s(input logic [127:0] w);
    data_s  = w[SW-1:0];
    valid_s = 1'b1;
    @(negedge clk);
    valid_s = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [127:0] w;
    logic [127:0] rw;
    logic [63:0]  r64;
    int           ecount;

    rst = 1'b1; sel = 2'd3; clear = 1'b0; valid = 1'b0; data = '0;
    clear_s = 1'b0; valid_s = 1'b0; data_s = '0;
    idle(3);
    rst = 1'b0;
    idle(1);
    chk("rst_locked", locked, 0);
    chk("rst_err", err, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_word_cnt", word_cnt, 0);

    // Clean lock on PRBS31: seed word + 16 matches.
    gen_init(3);
    for (int k = 0; k < 16; k++) begin gen_word(DW, w); send(w); end
    chk("prelock", locked, 0);
    gen_word(DW, w); send(w);
    $display("lock after 17 words: locked=%0d", locked);
    chk("lock", locked, 1);
    chk("lock_err_cnt", err_cnt, 0);
    chk("lock_word_cnt", word_cnt, 0);
    for (int k = 0; k < 5; k++) begin gen_word(DW, w); send(w); end
    chk("clean_word_cnt", word_cnt, 5);
    chk("clean_err_cnt", err_cnt, 0);

    // Single-bit error on bit 5.
    gen_word(DW, w); w[5] = ~w[5]; send(w);
    $display("bit5 error: err=%0d err_cnt=%0d", err, err_cnt);
    chk("bit5_err_o", err, 1);
    chk("bit5_err_cnt", err_cnt, 1);
    chk("bit5_locked", locked, 1);
    chk("bit5_word_cnt", word_cnt, 6);
    gen_word(DW, w); send(w);
    chk("after_err_o", err, 0);
    for (int k = 0; k < 3; k++) begin gen_word(DW, w); send(w); end
    chk("noprop_err_cnt", err_cnt, 1);
    chk("noprop_word_cnt", word_cnt, 10);

    // Clear without a word.
    clear = 1'b1; idle(1); clear = 1'b0;
    chk("clr_err_cnt", err_cnt, 0);
    chk("clr_word_cnt", word_cnt, 0);
    chk("clr_locked", locked, 1);

    // Lock loss: four words with three flipped bits each.
    for (int k = 0; k < 4; k++) begin
      gen_word(DW, w);
      w[1] = ~w[1]; w[17] = ~w[17]; w[40] = ~w[40];
      send(w);
      $display("burst word %0d: locked=%0d err_cnt=%0d", k, locked, err_cnt);
      chk("burst_locked", locked, (k < 3) ? 64'd1 : 64'd0);
    end
    chk("burst_err_cnt", err_cnt, 12);
    chk("burst_word_cnt", word_cnt, 4);

    // Relock after 16 clean words.
    for (int k = 0; k < 15; k++) begin gen_word(DW, w); send(w); end
    chk("relock_pre", locked, 0);
    gen_word(DW, w); send(w);
    chk("relock", locked, 1);
    chk("relock_err_cnt", err_cnt, 12);
    chk("relock_word_cnt", word_cnt, 4);

    // Valid gaps.
    for (int k = 0; k < 10; k++) begin
      idle($urandom_range(1, 5));
      gen_word(DW, w); send(w);
      chk("gap_err_o", err, 0);
    end
    chk("gap_err_cnt", err_cnt, 12);
    chk("gap_word_cnt", word_cnt, 14);
    chk("gap_locked", locked, 1);

    // Polynomial switch 3 -> 0.
    sel = 2'd0; idle(1);
    chk("sw_locked", locked, 0);
    chk("sw_err_cnt", err_cnt, 12);
    chk("sw_word_cnt", word_cnt, 14);
    gen_init(0);
    for (int k = 0; k < 16; k++) begin gen_word(DW, w); send(w); end
    chk("p7_prelock", locked, 0);
    gen_word(DW, w); send(w);
    $display("PRBS7 lock: locked=%0d", locked);
    chk("p7_lock", locked, 1);
    chk("p7_err_cnt", err_cnt, 12);
    chk("p7_word_cnt", word_cnt, 14);
    clear = 1'b1; idle(1); clear = 1'b0;
    chk("p7_clr_err", err_cnt, 0);
    chk("p7_clr_word", word_cnt, 0);

    // Reset mid-lock just after an errored word.
    gen_word(DW, w); w[63] = ~w[63]; send(w);
    chk("pre_rst_err_o", err, 1);
    chk("pre_rst_err_cnt", err_cnt, 1);
    rst = 1'b1; idle(1); rst = 1'b0;
    chk("mid_rst_locked", locked, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_err_cnt", err_cnt, 0);
    chk("mid_rst_word_cnt", word_cnt, 0);

    // Saturation on the 4-bit-counter instance (PRBS7, 40-bit words).
    gen_init(0);
    for (int k = 0; k < 17; k++) begin gen_word(SW, w); send_s(w); end
    chk("sat_lock", locked_s, 1);
    ecount = 0;
    for (int k = 0; k < 3; k++) begin
      gen_word(SW, w);
      r64 = {$urandom(), $urandom()};
      rw  = 128'(r64[SW-1:0]);
      ecount = ecount + $countones(rw[SW-1:0] ^ w[SW-1:0]);
      if (ecount > 15) ecount = 15;
      send_s(rw);
      $display("sat word %0d: err_cnt=%0d expect %0d", k, err_cnt_s, ecount);
      chk("sat_err_cnt", 64'(err_cnt_s), 64'(ecount));
      chk("sat_word_cnt", 64'(word_cnt_s), 64'(k + 1));
    end
    gen_word(SW, w);
    r64 = {$urandom(), $urandom()};
    rw  = 128'(r64[SW-1:0] ^ w[SW-1:0] ^ 64'h1);
    clear_s = 1'b1;
    send_s(rw);
    clear_s = 1'b0;
    chk("sat_clr_err_cnt", 64'(err_cnt_s), 0);
    chk("sat_clr_word_cnt", 64'(word_cnt_s), 0);
    chk("sat_drop", locked_s, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
